// File: rtl/layer_seq_ctrl_if.sv
// Bus between the layer sequencer and its surroundings: config/start in,
// buffer read/write strobes and the processing-unit stream out.
interface layer_seq_ctrl_if #(
    parameter int unsigned MAX_LAYERS = 4,
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned LAYER_W    = 2
);
    logic                          start_i;
    logic [LAYER_W-1:0]            num_layers_i;
    logic [MAX_LAYERS*LEN_W-1:0]   in_len_i;
    logic [MAX_LAYERS*LEN_W-1:0]   out_len_i;
    logic                          prcss_done_i;

    logic                          busy_o;
    logic [LAYER_W-1:0]            layer_o;
    logic                          x_buf_en_o;
    logic [LEN_W-1:0]              x_buf_addr_o;
    logic                          temp_rd_en_o;
    logic                          temp_rd_bank_o;
    logic [LEN_W-1:0]              temp_rd_addr_o;
    logic                          temp_wr_en_o;
    logic                          temp_wr_bank_o;
    logic [LEN_W-1:0]              temp_wr_addr_o;
    logic                          w_buf_en_o;
    logic [LAYER_W-1:0]            w_buf_sel_o;
    logic [LEN_W-1:0]              w_buf_addr_o;
    logic                          x_buf_mux_o;
    logic                          prcss_start_o;
    logic                          prcss_valid_o;
    logic                          prcss_last_o;
    logic                          done_intr_o;
    logic                          done_led_o;

    modport master (
        input  start_i, num_layers_i, in_len_i, out_len_i, prcss_done_i,
        output busy_o, layer_o, x_buf_en_o, x_buf_addr_o,
               temp_rd_en_o, temp_rd_bank_o, temp_rd_addr_o,
               temp_wr_en_o, temp_wr_bank_o, temp_wr_addr_o,
               w_buf_en_o, w_buf_sel_o, w_buf_addr_o, x_buf_mux_o,
               prcss_start_o, prcss_valid_o, prcss_last_o, done_intr_o, done_led_o
    );

    modport slave (
        output start_i, num_layers_i, in_len_i, out_len_i, prcss_done_i,
        input  busy_o, layer_o, x_buf_en_o, x_buf_addr_o,
               temp_rd_en_o, temp_rd_bank_o, temp_rd_addr_o,
               temp_wr_en_o, temp_wr_bank_o, temp_wr_addr_o,
               w_buf_en_o, w_buf_sel_o, w_buf_addr_o, x_buf_mux_o,
               prcss_start_o, prcss_valid_o, prcss_last_o, done_intr_o, done_led_o
    );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Global sequencer for the fully-connected datapath: walks layers and neurons,
// streams input/weight reads to the processing unit and writes results back.
module layer_seq_ctrl #(
    parameter int unsigned MAX_LAYERS = 4,
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned LAYER_W    = 2
) (
    input logic              clk,
    input logic              rst,
    layer_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {StIdle, StLayer, StStream, StWait, StWrite, StDone} state_e;

    state_e                      state_q, state_d;
    logic [LAYER_W-1:0]          num_layers_q;
    logic [LAYER_W-1:0]          layer_q, layer_d;
    logic [MAX_LAYERS*LEN_W-1:0] in_len_q, out_len_q;
    logic [LEN_W-1:0]            beat_q, beat_d;
    logic [LEN_W-1:0]            neuron_q, neuron_d;
    logic [LEN_W-1:0]            wa_q, wa_d;
    logic [LEN_W-1:0]            cur_in_len, cur_out_len;
    logic                        rd_bank_q, rd_bank_d;
    logic                        wr_bank_q, wr_bank_d;
    logic                        mux_q, mux_d;
    logic                        led_q, led_d;
    logic                        busy_q, x_en_q, t_en_q, w_en_q, wr_en_q;
    logic                        start_q, valid_q, last_q, intr_q;

    assign cur_in_len  = in_len_q[layer_q*LEN_W +: LEN_W];
    assign cur_out_len = out_len_q[layer_q*LEN_W +: LEN_W];

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        beat_d    = beat_q;
        neuron_d  = neuron_q;
        wa_d      = wa_q;
        rd_bank_d = rd_bank_q;
        wr_bank_d = wr_bank_q;
        mux_d     = mux_q;
        led_d     = led_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    layer_d   = '0;
                    rd_bank_d = 1'b0;
                    wr_bank_d = 1'b0;
                    mux_d     = 1'b0;
                    led_d     = 1'b0;
                    state_d   = StLayer;
                end
            end
            StLayer: begin
                neuron_d  = '0;
                beat_d    = '0;
                wa_d      = '0;
                rd_bank_d = ~layer_q[0];
                wr_bank_d = layer_q[0];
                mux_d     = (layer_q != '0);
                state_d   = StStream;
            end
            StStream: begin
                // Weight address runs across neurons; only LAYER rewinds it.
                wa_d = wa_q + LEN_W'(1);
                if (beat_q == cur_in_len) begin
                    state_d = StWait;
                end else begin
                    beat_d = beat_q + LEN_W'(1);
                end
            end
            StWait: begin
                if (bus.prcss_done_i) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (neuron_q < cur_out_len) begin
                    neuron_d = neuron_q + LEN_W'(1);
                    beat_d   = '0;
                    state_d  = StStream;
                end else if (layer_q < num_layers_q) begin
                    layer_d = layer_q + LAYER_W'(1);
                    state_d = StLayer;
                end else begin
                    led_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            num_layers_q <= '0;
            in_len_q     <= '0;
            out_len_q    <= '0;
            layer_q      <= '0;
            beat_q       <= '0;
            neuron_q     <= '0;
            wa_q         <= '0;
            rd_bank_q    <= 1'b0;
            wr_bank_q    <= 1'b0;
            mux_q        <= 1'b0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            x_en_q       <= 1'b0;
            t_en_q       <= 1'b0;
            w_en_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            start_q      <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            intr_q       <= 1'b0;
        end else begin
            if (state_q == StIdle && bus.start_i) begin
                num_layers_q <= bus.num_layers_i;
                in_len_q     <= bus.in_len_i;
                out_len_q    <= bus.out_len_i;
            end
            state_q   <= state_d;
            layer_q   <= layer_d;
            beat_q    <= beat_d;
            neuron_q  <= neuron_d;
            wa_q      <= wa_d;
            rd_bank_q <= rd_bank_d;
            wr_bank_q <= wr_bank_d;
            mux_q     <= mux_d;
            led_q     <= led_d;
            busy_q    <= (state_d != StIdle);
            x_en_q    <= (state_d == StStream) && (layer_d == '0);
            t_en_q    <= (state_d == StStream) && (layer_d != '0);
            w_en_q    <= (state_d == StStream);
            wr_en_q   <= (state_d == StWrite);
            intr_q    <= (state_d == StDone);
            // Stream strobes trail the issued read by one cycle to meet the data.
            valid_q   <= (state_q == StStream);
            start_q   <= (state_q == StStream) && (beat_q == '0);
            last_q    <= (state_q == StStream) && (beat_q == cur_in_len);
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.layer_o        = layer_q;
    assign bus.x_buf_en_o     = x_en_q;
    assign bus.x_buf_addr_o   = beat_q;
    assign bus.temp_rd_en_o   = t_en_q;
    assign bus.temp_rd_bank_o = rd_bank_q;
    assign bus.temp_rd_addr_o = beat_q;
    assign bus.temp_wr_en_o   = wr_en_q;
    assign bus.temp_wr_bank_o = wr_bank_q;
    assign bus.temp_wr_addr_o = neuron_q;
    assign bus.w_buf_en_o     = w_en_q;
    assign bus.w_buf_sel_o    = layer_q;
    assign bus.w_buf_addr_o   = wa_q;
    assign bus.x_buf_mux_o    = mux_q;
    assign bus.prcss_start_o  = start_q;
    assign bus.prcss_valid_o  = valid_q;
    assign bus.prcss_last_o   = last_q;
    assign bus.done_intr_o    = intr_q;
    assign bus.done_led_o     = led_q;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: table of runs checked against a read/stream/write
// scoreboard, plus hand sequences for reset abort and idle-state behaviour.
module tb_layer_seq_ctrl;
    localparam int unsigned MAX_LAYERS = 4;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned LAYER_W    = 2;

    typedef struct {
        logic [1:0]  nl;
        logic [15:0] in_len;
        logic [15:0] out_len;
        int          lat;
        bit          spur;
        bit          hold;
        int          exp_beats;
        int          exp_writes;
        bit          exp_bank;
    } vec_t;

    typedef struct {
        bit         xsrc;
        bit         bank;
        logic [3:0] addr;
        logic [3:0] waddr;
        logic [1:0] sel;
        bit         mux;
    } rd_t;

    logic clk;
    logic rst;
    layer_seq_ctrl_if #(.MAX_LAYERS(MAX_LAYERS), .LEN_W(LEN_W), .LAYER_W(LAYER_W)) bus ();

    layer_seq_ctrl #(.MAX_LAYERS(MAX_LAYERS), .LEN_W(LEN_W), .LAYER_W(LAYER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rd_t        rd_q[$];
    logic [1:0] vl_q[$];
    logic [4:0] wr_q[$];
    vec_t       vecs[5];
    int         tests, fails;
    int         done_cnt, beats_seen, writes_seen;
    bit         last_bank;
    int         lat, pend;
    bit         spur, idle_poke;
    bit         prev_w_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] all_outs();
        return {bus.busy_o, bus.layer_o, bus.x_buf_en_o, bus.x_buf_addr_o, bus.temp_rd_en_o,
                bus.temp_rd_bank_o, bus.temp_rd_addr_o, bus.temp_wr_en_o, bus.temp_wr_bank_o,
                bus.temp_wr_addr_o, bus.w_buf_en_o, bus.w_buf_sel_o, bus.w_buf_addr_o,
                bus.x_buf_mux_o, bus.prcss_start_o, bus.prcss_valid_o, bus.prcss_last_o,
                bus.done_intr_o, bus.done_led_o};
    endfunction

    // Reference model: every read beat, stream strobe pair and write of one run.
    task automatic push_model(input vec_t v);
        rd_t r;
        int  wa;
        for (int l = 0; l <= int'(v.nl); l++) begin
            int il = int'(v.in_len[l*4 +: 4]);
            int ol = int'(v.out_len[l*4 +: 4]);
            wa = 0;
            for (int n = 0; n <= ol; n++) begin
                for (int i = 0; i <= il; i++) begin
                    r.xsrc  = (l == 0);
                    r.bank  = ((l % 2) == 0);
                    r.addr  = 4'(i);
                    r.waddr = 4'(wa);
                    r.sel   = 2'(l);
                    r.mux   = (l != 0);
                    rd_q.push_back(r);
                    vl_q.push_back({i == 0, i == il});
                    wa++;
                end
                wr_q.push_back({((l % 2) == 1), 4'(n)});
            end
        end
    endtask

    // Processing-unit model: answers each neuron after lat cycles, optionally
    // throws done pulses while idle or streaming.
    initial begin
        pend = -1;
        bus.prcss_done_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.prcss_done_i = 1'b0;
            if (rst) begin
                pend = -1;
            end else begin
                if (pend == 0) begin
                    bus.prcss_done_i = 1'b1;
                    pend = -1;
                end else if (pend > 0) begin
                    pend--;
                end
                if (bus.prcss_valid_o && bus.prcss_last_o) begin
                    if (lat == 0) bus.prcss_done_i = 1'b1;
                    else pend = lat - 1;
                end
                if (spur && bus.w_buf_en_o) bus.prcss_done_i = 1'b1;
                if (idle_poke && !bus.busy_o) bus.prcss_done_i = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard as the DUT produces beats and writes.
    initial begin
        rd_t        e;
        logic [1:0] ev;
        logic [4:0] ew;
        prev_w_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.x_buf_en_o || bus.temp_rd_en_o || bus.w_buf_en_o)
                    check("src_en_vs_w_en", bus.x_buf_en_o | bus.temp_rd_en_o, bus.w_buf_en_o);
                if (bus.w_buf_en_o) begin
                    beats_seen++;
                    if (rd_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = rd_q.pop_front();
                        if (e.xsrc)
                            check("rd_beat", {bus.x_buf_en_o, bus.temp_rd_en_o, 1'b0,
                                  bus.x_buf_addr_o, bus.w_buf_addr_o, bus.w_buf_sel_o,
                                  bus.x_buf_mux_o},
                                  {2'b10, 1'b0, e.addr, e.waddr, e.sel, e.mux});
                        else
                            check("rd_beat", {bus.x_buf_en_o, bus.temp_rd_en_o,
                                  bus.temp_rd_bank_o, bus.temp_rd_addr_o, bus.w_buf_addr_o,
                                  bus.w_buf_sel_o, bus.x_buf_mux_o},
                                  {2'b01, e.bank, e.addr, e.waddr, e.sel, e.mux});
                    end
                end
                if (bus.prcss_valid_o || prev_w_en)
                    check("valid_lag", bus.prcss_valid_o, prev_w_en);
                if ((bus.prcss_start_o || bus.prcss_last_o) && !bus.prcss_valid_o)
                    check("strobe_without_valid", 1, 0);
                if (bus.prcss_valid_o) begin
                    if (vl_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        ev = vl_q.pop_front();
                        check("start_last", {bus.prcss_start_o, bus.prcss_last_o}, ev);
                    end
                end
                if (bus.temp_wr_en_o) begin
                    writes_seen++;
                    last_bank = bus.temp_wr_bank_o;
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        ew = wr_q.pop_front();
                        check("wr_bank_addr", {bus.temp_wr_bank_o, bus.temp_wr_addr_o}, ew);
                    end
                end
                if (bus.done_intr_o) done_cnt++;
            end
            prev_w_en = bus.w_buf_en_o;
        end
    end

    task automatic apply_cfg(input vec_t v);
        bus.num_layers_i = v.nl;
        bus.in_len_i     = v.in_len;
        bus.out_len_i    = v.out_len;
        lat              = v.lat;
        spur             = v.spur;
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        int cyc;
        apply_cfg(v);
        push_model(v);
        beats_seen  = 0;
        writes_seen = 0;
        d0          = done_cnt;
        bus.start_i = 1'b1;
        @(negedge clk);
        if (!v.hold) bus.start_i = 1'b0;
        check("start_accept", {bus.busy_o, bus.done_led_o, bus.x_buf_en_o, bus.layer_o},
              {1'b1, 1'b0, 1'b0, 2'd0});
        @(negedge clk);
        check("first_x_beat", {bus.x_buf_en_o, bus.x_buf_addr_o}, {1'b1, 4'd0});
        cyc = 0;
        while (!bus.done_intr_o && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", cyc < 3000, 1);
        bus.start_i = 1'b0;
        @(negedge clk);
        check("after_done", {bus.done_intr_o, bus.busy_o, bus.done_led_o}, 3'b001);
        repeat (4) @(negedge clk);
        check("done_count", done_cnt - d0, 1);
        check("beats", beats_seen, v.exp_beats);
        check("writes", writes_seen, v.exp_writes);
        check("final_bank", last_bank, v.exp_bank);
        check("queues_empty", rd_q.size() + vl_q.size() + wr_q.size(), 0);
        check("idle_after_run", {bus.busy_o, bus.done_led_o}, 2'b01);
    endtask

    initial begin
        vec_t ab;
        int   cyc;
        int   w0, d0;
        tests = 0; fails = 0; done_cnt = 0; beats_seen = 0; writes_seen = 0;
        last_bank = 1'b0; lat = 0; spur = 1'b0; idle_poke = 1'b0;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.num_layers_i = '0; bus.in_len_i = '0; bus.out_len_i = '0;
        // Unused length slots hold 4'hF so a wrong slot select shows up.
        vecs[0] = '{nl: 2'd0, in_len: 16'hFFF3, out_len: 16'hFFF1, lat: 2, spur: 0, hold: 0,
                    exp_beats: 8, exp_writes: 2, exp_bank: 0};
        vecs[1] = '{nl: 2'd2, in_len: 16'hF212, out_len: 16'hF021, lat: 1, spur: 0, hold: 0,
                    exp_beats: 15, exp_writes: 6, exp_bank: 0};
        vecs[2] = '{nl: 2'd1, in_len: 16'hFF00, out_len: 16'hFF12, lat: 0, spur: 0, hold: 0,
                    exp_beats: 5, exp_writes: 5, exp_bank: 1};
        vecs[3] = '{nl: 2'd0, in_len: 16'hFFF7, out_len: 16'hFFF2, lat: 3, spur: 1, hold: 0,
                    exp_beats: 24, exp_writes: 3, exp_bank: 0};
        vecs[4] = '{nl: 2'd3, in_len: 16'h1201, out_len: 16'h2010, lat: 0, spur: 0, hold: 1,
                    exp_beats: 13, exp_writes: 7, exp_bank: 1};
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;

        idle_poke = 1'b1;
        repeat (3) @(negedge clk);
        idle_poke = 1'b0;
        @(negedge clk);
        check("idle_done_ignored", all_outs(), 0);

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        rst = 1'b1;
        @(negedge clk);
        check("rst_clears_led", bus.done_led_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Abort in the WAIT state of layer 1.
        ab = '{nl: 2'd1, in_len: 16'hFF11, out_len: 16'hFF01, lat: 6, spur: 0, hold: 0,
               exp_beats: 0, exp_writes: 0, exp_bank: 0};
        apply_cfg(ab);
        push_model(ab);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        cyc = 0;
        while (!(bus.prcss_valid_o && bus.prcss_last_o && bus.layer_o == 2'd1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_timeout", cyc < 500, 1);
        w0 = writes_seen;
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", all_outs(), 0);
        rd_q.delete();
        vl_q.delete();
        wr_q.delete();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_write", writes_seen - w0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", all_outs(), 0);
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
